// File: rtl/mm_stream_bridge_pkg.sv
// Shared constants and state encoding for the matrix-multiply bridge
// and the engine behind it.
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_RD_ISSUE,
    S_RD_HOLD
  } state_e;

  localparam int L_RAM_SIZE_DEF = 3;

  function automatic int addr_w(input int l);
    return 2 * l + 1;
  endfunction

  function automatic int mat_size(input int l);
    return 2 ** (2 * l);
  endfunction

  function automatic int mat_size2(input int l);
    return 2 * mat_size(l);
  endfunction

endpackage

// File: rtl/mm_stream_bridge_if.sv
// Stream, shared-BRAM and engine signals of the bridge.
// The bridge side is master and the environment side is slave.
interface mm_stream_bridge_if
  import mm_pkg::*;
#(
  parameter int AW = addr_w(L_RAM_SIZE_DEF),
  parameter int DW = 32
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wrdata;
  logic          bram_we;
  logic [DW-1:0] bram_rddata;
  logic          mm_start;
  logic          mm_done;
  logic [AW-1:0] mm_addr;
  logic [DW-1:0] mm_wrdata;
  logic          mm_we;

  modport master (
    input  s_valid, s_data, m_ready,
    input  bram_rddata, mm_done,
    input  mm_addr, mm_wrdata, mm_we,
    output s_ready, m_valid, m_data, m_last,
    output bram_addr, bram_wrdata, bram_we,
    output mm_start
  );

  modport slave (
    output s_valid, s_data, m_ready,
    output bram_rddata, mm_done,
    output mm_addr, mm_wrdata, mm_we,
    input  s_ready, m_valid, m_data, m_last,
    input  bram_addr, bram_wrdata, bram_we,
    input  mm_start
  );
endinterface

// File: rtl/mm_stream_bridge_mux.sv
// Shared BRAM port mux; the select is registered so the port
// changes owner on the cycle after the state decides it.
module mm_bram_mux #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel_d_i,
  input  logic [AW-1:0] br_addr_i,
  input  logic [DW-1:0] br_wrdata_i,
  input  logic          br_we_i,
  input  logic [AW-1:0] en_addr_i,
  input  logic [DW-1:0] en_wrdata_i,
  input  logic          en_we_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wrdata_o,
  output logic          we_o
);
  logic sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= 1'b0;
    else       sel_q <= sel_d_i;
  end

  assign addr_o   = sel_q ? en_addr_i   : br_addr_i;
  assign wrdata_o = sel_q ? en_wrdata_i : br_wrdata_i;
  assign we_o     = sel_q ? en_we_i     : br_we_i;
endmodule

// File: rtl/mm_stream_bridge.sv
// Stream front-end of the matrix-multiply engine: loads A and B,
// runs the engine on the shared BRAM, then streams the results out.
module mm_stream_bridge
  import mm_pkg::*;
#(
  parameter int L_RAM_SIZE     = 3,
  parameter int BITWIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  mm_stream_bridge_if.master bus,
  output logic busy,
  output logic error
);
  localparam int AW = addr_w(L_RAM_SIZE);
  localparam int M  = mat_size(L_RAM_SIZE);
  localparam int M2 = mat_size2(L_RAM_SIZE);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] LAST_LD = AW'(M2 - 1);
  localparam logic [AW-1:0] LAST_RD = AW'(M - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  err_q, err_d;
  logic                  vld_q, vld_d;
  logic [BITWIDTH-1:0]   data_q, data_d;
  logic                  done_q;
  logic                  s_rdy, beat, done_rise;
  logic                  br_we;
  logic [BITWIDTH-1:0]   br_wd;

  assign s_rdy = ~reset &
    ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign beat      = bus.s_valid & s_rdy;
  assign done_rise = bus.mm_done & ~done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      done_q  <= bus.mm_done;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    err_d        = err_q;
    vld_d        = vld_q;
    data_d       = data_q;
    br_we        = 1'b0;
    br_wd        = '0;
    bus.mm_start = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (beat) begin
          br_we   = 1'b1;
          br_wd   = bus.s_data;
          err_d   = 1'b0;
          cnt_d   = AW'(1);
          state_d = S_LOAD;
        end
      end
      (state_q == S_LOAD): begin
        if (beat) begin
          br_we = 1'b1;
          br_wd = bus.s_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_LD) begin
            cnt_d   = '0;
            state_d = S_START;
          end
        end
      end
      (state_q == S_START): begin
        bus.mm_start = 1'b1;
        timer_d      = '0;
        state_d      = S_RUN;
      end
      (state_q == S_RUN): begin
        timer_d = timer_q + 1'b1;
        // A done rise wins over a timeout landing on the same cycle.
        if (done_rise) begin
          cnt_d   = '0;
          state_d = S_RD_ISSUE;
        end else if (timer_d == T_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      (state_q == S_RD_ISSUE): begin
        vld_d   = 1'b0;
        state_d = S_RD_HOLD;
      end
      (state_q == S_RD_HOLD): begin
        if (!vld_q) begin
          data_d = bus.bram_rddata;
          vld_d  = 1'b1;
        end else if (bus.m_ready) begin
          vld_d = 1'b0;
          if (cnt_q == LAST_RD) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  mm_bram_mux #(.AW(AW), .DW(BITWIDTH)) u_mux (
    .clk         (clk),
    .reset       (reset),
    .sel_d_i     (state_d == S_RUN),
    .br_addr_i   (cnt_q),
    .br_wrdata_i (br_wd),
    .br_we_i     (br_we),
    .en_addr_i   (bus.mm_addr),
    .en_wrdata_i (bus.mm_wrdata),
    .en_we_i     (bus.mm_we),
    .addr_o      (bus.bram_addr),
    .wrdata_o    (bus.bram_wrdata),
    .we_o        (bus.bram_we)
  );

  assign bus.s_ready = s_rdy;
  assign bus.m_valid = vld_q;
  assign bus.m_data  = data_q;
  assign bus.m_last  = vld_q & (cnt_q == LAST_RD);
  assign busy        = (state_q != S_IDLE);
  assign error       = err_q;
endmodule

// File: tb/tb_mm_stream_bridge.sv
// Directed bench: BRAM and engine models around the bridge,
// vector table for the engine passthrough, sequences for the rest.
module tb_mm_stream_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, error;

  mm_stream_bridge_if #(.AW(7), .DW(32)) bus ();

  mm_stream_bridge #(
    .L_RAM_SIZE(3), .BITWIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [128];
  logic [31:0] rd_q;
  int          wcnt [128];
  logic [31:0] eng_c [64];
  logic        eng_commit = 1'b0;
  logic        wclr = 1'b0;
  int          cyc_n = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    rd_q  <= mem[bus.bram_addr];
    if (bus.bram_we) begin
      mem[bus.bram_addr]  <= bus.bram_wrdata;
      wcnt[bus.bram_addr] <= wcnt[bus.bram_addr] + 1;
    end
    if (eng_commit)
      for (int i = 0; i < 64; i++) mem[i] <= eng_c[i];
    if (wclr)
      for (int i = 0; i < 128; i++) wcnt[i] <= 0;
  end
  assign bus.bram_rddata = rd_q;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int w);
    if (w < 64) return ((w / 8) == (w % 8)) ? 32'd1 : 32'd0;
    return 32'(w - 64);
  endfunction

  // Streams all 128 operands; returns on the START-cycle negedge.
  task automatic load(input bit gap, input bit chk_err);
    int w = 0;
    int cyc = 0;
    int guard = 0;
    bit e1 = 0;
    while (w < 128 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (chk_err && w == 1 && !e1) begin
        chk("err_cleared", error, 0);
        e1 = 1;
      end
      chk("no_early_start", bus.mm_start, 0);
      bus.s_valid = !(gap && (cyc % 3 == 2));
      bus.s_data  = word(w);
      #1;
      if (bus.s_valid && bus.s_ready) begin
        if (chk_err && w == 0) chk("err_held", error, 1);
        chk("ld_we", bus.bram_we, 1);
        chk("ld_addr", bus.bram_addr, w);
        chk("ld_data", bus.bram_wrdata, word(w));
        w++;
      end else begin
        chk("ld_nowe", bus.bram_we, 0);
      end
      cyc++;
    end
    if (w < 128) chk("load_timeout", w, 128);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("start_pulse", bus.mm_start, 1);
    chk("start_srdy", bus.s_ready, 0);
    chk("start_busy", busy, 1);
  endtask

  // Engine model: C = A*B into 0..63, then a 3-cycle done level.
  task automatic engine();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        logic [31:0] s = 0;
        for (int k = 0; k < 8; k++)
          s += mem[i*8+k] * mem[64+k*8+j];
        eng_c[i*8+j] = s;
      end
    @(negedge clk);
    chk("start_one_cycle", bus.mm_start, 0);
    eng_commit = 1'b1;
    @(negedge clk);
    eng_commit  = 1'b0;
    bus.mm_done = 1'b1;
    repeat (3) @(negedge clk);
    bus.mm_done = 1'b0;
  endtask

  task automatic read_out(input int bp);
    int prev = 0;
    for (int j = 0; j < 64; j++) begin
      int g = 0;
      while (!bus.m_valid && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (!bus.m_valid) begin
        chk("rd_timeout", j, 64);
        return;
      end
      if (j > 0) chk("rd_gap", cyc_n - prev, 3);
      chk("rd_data", bus.m_data, j);
      chk("rd_last", bus.m_last, (j == 63));
      if (j == bp) begin
        logic [6:0] a0 = bus.bram_addr;
        repeat (10) begin
          @(negedge clk);
          chk("bp_valid", bus.m_valid, 1);
          chk("bp_data", bus.m_data, j);
          chk("bp_addr", bus.bram_addr, a0);
        end
      end
      bus.m_ready = 1'b1;
      prev = cyc_n;
      @(negedge clk);
      bus.m_ready = 1'b0;
      chk("rd_drop", bus.m_valid, 0);
    end
    chk("rd_idle", busy, 0);
  endtask

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] wd;
    logic        we;
    logic        sv;
    logic [6:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_we;
    logic        e_srdy;
  } pvec_t;
  pvec_t vt [4];

  initial begin
    vt[0] = '{7'd17, 32'hDEADBEEF, 1'b1, 1'b1,
              7'd17, 32'hDEADBEEF, 1'b1, 1'b0};
    vt[1] = '{7'd0, 32'h0, 1'b0, 1'b0,
              7'd0, 32'h0, 1'b0, 1'b0};
    vt[2] = '{7'd127, 32'h12345678, 1'b1, 1'b0,
              7'd127, 32'h12345678, 1'b1, 1'b0};
    vt[3] = '{7'd64, 32'hFFFFFFFF, 1'b0, 1'b1,
              7'd64, 32'hFFFFFFFF, 1'b0, 1'b0};

    bus.s_valid = 0; bus.s_data = 0; bus.m_ready = 0;
    bus.mm_done = 0; bus.mm_addr = 0;
    bus.mm_wrdata = 0; bus.mm_we = 0;
    #1;
    chk("rst_srdy", bus.s_ready, 0);
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_mlast", bus.m_last, 0);
    chk("rst_start", bus.mm_start, 0);
    chk("rst_we", bus.bram_we, 0);
    chk("rst_addr", bus.bram_addr, 0);
    chk("rst_wd", bus.bram_wrdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    load(0, 0);
    engine();
    read_out(-1);

    @(negedge clk) wclr = 1'b1;
    @(negedge clk) wclr = 1'b0;
    load(1, 0);
    begin
      int bad = 0;
      int tot = 0;
      for (int a = 0; a < 128; a++) begin
        if (wcnt[a] != 1) bad++;
        tot += wcnt[a];
      end
      chk("wr_once", bad, 0);
      chk("wr_total", tot, 128);
    end
    engine();
    read_out(5);

    load(0, 0);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n >= 2 && n <= 5) begin
        bus.mm_addr   = vt[n-2].addr;
        bus.mm_wrdata = vt[n-2].wd;
        bus.mm_we     = vt[n-2].we;
        bus.s_valid   = vt[n-2].sv;
        #1;
        chk("pt_addr", bus.bram_addr, vt[n-2].e_addr);
        chk("pt_wd", bus.bram_wrdata, vt[n-2].e_wd);
        chk("pt_we", bus.bram_we, vt[n-2].e_we);
        chk("pt_srdy", bus.s_ready, vt[n-2].e_srdy);
      end else begin
        bus.mm_we = 0; bus.s_valid = 0;
      end
      if (n == 15) begin
        chk("to_busy15", busy, 1);
        chk("to_err15", error, 0);
      end
      if (n == 16) begin
        chk("to_err16", error, 1);
        chk("to_busy16", busy, 0);
        chk("to_srdy16", bus.s_ready, 1);
      end
    end
    bus.mm_addr = 0; bus.mm_wrdata = 0;

    load(0, 1);
    engine();
    read_out(-1);

    load(0, 0);
    @(negedge clk);
    bus.mm_addr = 7'd5; bus.mm_wrdata = 32'd7; bus.mm_we = 1'b1;
    #1;
    chk("run_we", bus.bram_we, 1);
    chk("run_addr", bus.bram_addr, 5);
    #1 reset = 1'b1;
    #1;
    chk("ar_start", bus.mm_start, 0);
    chk("ar_we", bus.bram_we, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", bus.bram_addr, 0);
    chk("ar_srdy", bus.s_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.mm_we = 0; bus.mm_addr = 0; bus.mm_wrdata = 0;
    load(0, 0);
    engine();
    read_out(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
endmodule
